modn_counter_sched: RTL and testbench

Round-robin scheduler that shares one mod-N up/down counter between two requesters. Each requester asks for a move of a given number of steps in a given direction. The block grants one request at a time, steps the counter once per clock until the move completes, then pulses done. It sits between the two command sources and the counter, and the counter register is embedded in this block.

---
 rtl/modn_counter_sched_if.sv | 28 ++
 rtl/modn_counter_sched.sv | 110 +++++++++++
 tb/tb_modn_counter_sched.sv | 222 ++++++++++++++++++++++
 3 files changed

// File: rtl/modn_counter_sched_if.sv
// Command/status bundle between the two requesters and the shared mod-N counter scheduler.
// Requesters drive the master modport and the scheduler takes the slave modport.
interface modn_counter_sched_if #(
  parameter int WIDTH = 4,
  parameter int STEPW = 4
);
  logic [1:0]       req;
  logic             dir0;
  logic [STEPW-1:0] steps0;
  logic             dir1;
  logic [STEPW-1:0] steps1;
  logic [1:0]       gnt;
  logic             busy;
  logic             owner;
  logic [WIDTH-1:0] count;
  logic             wrap;
  logic [1:0]       done;

  modport master (
    output req, dir0, steps0, dir1, steps1,
    input  gnt, busy, owner, count, wrap, done
  );

  modport slave (
    input  req, dir0, steps0, dir1, steps1,
    output gnt, busy, owner, count, wrap, done
  );
endinterface

// File: rtl/modn_counter_sched.sv
// Round-robin arbiter sharing one embedded mod-N up/down counter between two requesters;
// a granted move steps the counter once per clock and pulses done when it completes.
module modn_counter_sched #(
  parameter int N     = 10,
  parameter int WIDTH = 4,
  parameter int STEPW = 4
) (
  input logic                 clk,
  input logic                 reset,
  modn_counter_sched_if.slave sched
);

  typedef enum logic {IDLE, RUN} state_e;

  localparam logic [WIDTH-1:0] MaxCnt = WIDTH'(N - 1);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] cnt_q, cnt_d;
  logic [STEPW-1:0] rem_q, rem_d;
  logic             dir_q, dir_d;
  logic             owner_q, owner_d;
  logic             ptr_q, ptr_d;
  logic [1:0]       gnt_q, gnt_d;
  logic [1:0]       done_q, done_d;
  logic             wrap_q, wrap_d;

  logic             win;
  logic             winDir;
  logic [STEPW-1:0] winSteps;

  // With both requests raised the pointer decides; otherwise the single raised bit wins.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    rem_d    = rem_q;
    dir_d    = dir_q;
    owner_d  = owner_q;
    ptr_d    = ptr_q;
    gnt_d    = 2'b00;
    done_d   = 2'b00;
    wrap_d   = 1'b0;
    win      = (sched.req == 2'b11) ? ptr_q : sched.req[1];
    winDir   = win ? sched.dir1 : sched.dir0;
    winSteps = win ? sched.steps1 : sched.steps0;

    case (state_q)
      IDLE: begin
        if (sched.req != 2'b00) begin
          owner_d = win;
          ptr_d   = ~win;
          dir_d   = winDir;
          gnt_d   = win ? 2'b10 : 2'b01;
          if (winSteps == '0) begin
            done_d = win ? 2'b10 : 2'b01;
          end else begin
            rem_d   = winSteps;
            state_d = RUN;
          end
        end
      end
      RUN: begin
        if (dir_q) begin
          wrap_d = (cnt_q == MaxCnt);
          cnt_d  = wrap_d ? '0 : cnt_q + WIDTH'(1);
        end else begin
          wrap_d = (cnt_q == '0);
          cnt_d  = wrap_d ? MaxCnt : cnt_q - WIDTH'(1);
        end
        rem_d = rem_q - STEPW'(1);
        if (rem_q == STEPW'(1)) begin
          done_d  = owner_q ? 2'b10 : 2'b01;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      rem_q   <= '0;
      dir_q   <= 1'b0;
      owner_q <= 1'b0;
      ptr_q   <= 1'b0;
      gnt_q   <= 2'b00;
      done_q  <= 2'b00;
      wrap_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rem_q   <= rem_d;
      dir_q   <= dir_d;
      owner_q <= owner_d;
      ptr_q   <= ptr_d;
      gnt_q   <= gnt_d;
      done_q  <= done_d;
      wrap_q  <= wrap_d;
    end
  end

  assign sched.gnt   = gnt_q;
  assign sched.busy  = (state_q == RUN);
  assign sched.owner = owner_q;
  assign sched.count = cnt_q;
  assign sched.wrap  = wrap_q;
  assign sched.done  = done_q;

endmodule

// File: tb/tb_modn_counter_sched.sv
// Self-checking bench for modn_counter_sched: a table of moves with hand-computed results,
// checked through a scoreboard queue, plus round-robin and mid-move reset sequences.
module tb_modn_counter_sched;
  localparam int N     = 10;
  localparam int WIDTH = 4;
  localparam int STEPW = 4;

  logic clk = 1'b0;
  logic reset;

  always #5 clk = ~clk;

  modn_counter_sched_if #(.WIDTH(WIDTH), .STEPW(STEPW)) bus ();

  modn_counter_sched #(.N(N), .WIDTH(WIDTH), .STEPW(STEPW)) dut (
    .clk   (clk),
    .reset (reset),
    .sched (bus)
  );

  typedef struct {
    logic [1:0]       req;
    logic             d0;
    logic [STEPW-1:0] s0;
    logic             d1;
    logic [STEPW-1:0] s1;
    logic [1:0]       expGnt;
    logic [WIDTH-1:0] expCount;
    int               expWraps;
    int               expBusy;
  } vec_t;

  typedef struct {
    logic [1:0]       gnt;
    logic [WIDTH-1:0] count;
    int               wraps;
    int               busyCycles;
  } exp_t;

  exp_t sbq[$];
  int   gntTimes[$];
  int   checks = 0;
  int   fails = 0;
  int   cycle = 0;
  bit   monitorOn = 1'b0;
  int   wrapAcc = 0;
  int   busyAcc = 0;
  vec_t vecs[8];

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      fails++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  always @(posedge clk) cycle++;

  // Moves are matched to expectations in order: gnt opens an entry, done closes it.
  always @(negedge clk) begin
    exp_t e;
    if (monitorOn) begin
      checkOutput("count range", 32'(bus.count < WIDTH'(N)), 1);
      if (bus.gnt != 2'b00) begin
        gntTimes.push_back(cycle);
        if (sbq.size() == 0) begin
          checkOutput("unexpected gnt", 32'(bus.gnt), 0);
        end else begin
          checkOutput("gnt", 32'(bus.gnt), 32'(sbq[0].gnt));
          checkOutput("owner", 32'(bus.owner), 32'(sbq[0].gnt[1]));
        end
        wrapAcc = 0;
        busyAcc = 0;
      end
      if (bus.busy) busyAcc++;
      if (bus.wrap) wrapAcc++;
      if (bus.done != 2'b00) begin
        if (sbq.size() == 0) begin
          checkOutput("unexpected done", 32'(bus.done), 0);
        end else begin
          e = sbq.pop_front();
          checkOutput("done", 32'(bus.done), 32'(e.gnt));
          checkOutput("final count", 32'(bus.count), 32'(e.count));
          checkOutput("wrap pulses", wrapAcc, e.wraps);
          checkOutput("busy cycles", busyAcc, e.busyCycles);
        end
      end
    end
  end

  task automatic waitDrained(input string name);
    for (int i = 0; i < 60 && sbq.size() != 0; i++) @(negedge clk);
    @(negedge clk);
    if (sbq.size() != 0) begin
      checkOutput({name, " timeout"}, sbq.size(), 0);
      sbq.delete();
    end
  endtask

  task automatic doReset();
    @(negedge clk);
    reset = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
  endtask

  // Raise req for exactly one rising edge, then wait for the move to complete.
  task automatic applyStimulus(input vec_t v);
    exp_t e;
    @(negedge clk);
    bus.req    = v.req;
    bus.dir0   = v.d0;
    bus.steps0 = v.s0;
    bus.dir1   = v.d1;
    bus.steps1 = v.s1;
    e.gnt        = v.expGnt;
    e.count      = v.expCount;
    e.wraps      = v.expWraps;
    e.busyCycles = v.expBusy;
    sbq.push_back(e);
    @(negedge clk);
    bus.req = 2'b00;
    waitDrained("move");
  endtask

  task automatic pushExp(input logic [1:0] g, input logic [WIDTH-1:0] c, input int w, input int b);
    exp_t e;
    e.gnt        = g;
    e.count      = c;
    e.wraps      = w;
    e.busyCycles = b;
    sbq.push_back(e);
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    reset      = 1'b1;
    bus.req    = 2'b00;
    bus.dir0   = 1'b0;
    bus.steps0 = '0;
    bus.dir1   = 1'b0;
    bus.steps1 = '0;

    // Counts continue from one move to the next, starting at 0 after reset.
    vecs[0] = '{2'b01, 1'b1, 4'd3,  1'b0, 4'd0, 2'b01, 4'd3, 0, 3};
    vecs[1] = '{2'b01, 1'b1, 4'd0,  1'b0, 4'd0, 2'b01, 4'd3, 0, 0};
    vecs[2] = '{2'b10, 1'b0, 4'd0,  1'b0, 4'd3, 2'b10, 4'd0, 0, 3};
    vecs[3] = '{2'b10, 1'b0, 4'd0,  1'b0, 4'd2, 2'b10, 4'd8, 1, 2};
    vecs[4] = '{2'b01, 1'b1, 4'd12, 1'b0, 4'd0, 2'b01, 4'd0, 2, 12};
    vecs[5] = '{2'b11, 1'b1, 4'd1,  1'b0, 4'd2, 2'b10, 4'd8, 1, 2};
    vecs[6] = '{2'b11, 1'b0, 4'd4,  1'b1, 4'd1, 2'b01, 4'd4, 0, 4};
    vecs[7] = '{2'b01, 1'b1, 4'd15, 1'b0, 4'd0, 2'b01, 4'd9, 1, 15};

    repeat (2) @(negedge clk);
    reset = 1'b0;
    checkOutput("reset count", 32'(bus.count), 0);
    checkOutput("reset gnt",   32'(bus.gnt),   0);
    checkOutput("reset done",  32'(bus.done),  0);
    checkOutput("reset wrap",  32'(bus.wrap),  0);
    checkOutput("reset busy",  32'(bus.busy),  0);
    checkOutput("reset owner", 32'(bus.owner), 0);

    monitorOn = 1'b1;
    for (int i = 0; i < 8; i++) applyStimulus(vecs[i]);

    // Both requesters held with single up-steps: grants alternate two cycles apart.
    monitorOn = 1'b0;
    doReset();
    monitorOn = 1'b1;
    gntTimes.delete();
    pushExp(2'b01, 4'd1, 0, 1);
    pushExp(2'b10, 4'd2, 0, 1);
    pushExp(2'b01, 4'd3, 0, 1);
    pushExp(2'b10, 4'd4, 0, 1);
    @(negedge clk);
    bus.req    = 2'b11;
    bus.dir0   = 1'b1;
    bus.steps0 = 4'd1;
    bus.dir1   = 1'b1;
    bus.steps1 = 4'd1;
    repeat (7) @(negedge clk);
    bus.req = 2'b00;
    waitDrained("round robin");
    checkOutput("rr grant count", gntTimes.size(), 4);
    if (gntTimes.size() == 4) begin
      for (int i = 1; i < 4; i++) checkOutput("rr grant spacing", gntTimes[i] - gntTimes[i-1], 2);
    end

    // Reset two steps into a five-step move aborts it silently.
    monitorOn = 1'b0;
    doReset();
    @(negedge clk);
    bus.req    = 2'b01;
    bus.dir0   = 1'b1;
    bus.steps0 = 4'd5;
    @(negedge clk);
    bus.req = 2'b00;
    checkOutput("abort gnt", 32'(bus.gnt), 32'(2'b01));
    repeat (2) @(negedge clk);
    checkOutput("abort pre count", 32'(bus.count), 2);
    checkOutput("abort pre busy",  32'(bus.busy),  1);
    reset = 1'b1;
    @(negedge clk);
    checkOutput("abort count", 32'(bus.count), 0);
    checkOutput("abort busy",  32'(bus.busy),  0);
    checkOutput("abort done",  32'(bus.done),  0);
    checkOutput("abort owner", 32'(bus.owner), 0);
    reset = 1'b0;
    monitorOn = 1'b1;
    applyStimulus('{2'b11, 1'b1, 4'd1, 1'b1, 4'd1, 2'b01, 4'd1, 0, 1});

    monitorOn = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule
